// File: rtl/ntt_bu_pipe_if.sv
// Operand/result handshake bundle for the NTT butterfly pipeline.
// The slave modport is the butterfly's view; the master modport is the producer/consumer side.
interface ntt_bu_pipe_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  in_valid_i;
  logic                  in_ready_o;
  logic                  mode_i;
  logic [DATA_WIDTH-1:0] data1_i;
  logic [DATA_WIDTH-1:0] data2_i;
  logic [DATA_WIDTH-1:0] w_i;
  logic                  out_valid_o;
  logic                  out_ready_i;
  logic [DATA_WIDTH-1:0] ntt_data1_o;
  logic [DATA_WIDTH-1:0] ntt_data2_o;
  logic [2:0]            inflight_o;

  modport slave (
    input  in_valid_i, mode_i, data1_i, data2_i, w_i, out_ready_i,
    output in_ready_o, out_valid_o, ntt_data1_o, ntt_data2_o, inflight_o
  );

  modport master (
    output in_valid_i, mode_i, data1_i, data2_i, w_i, out_ready_i,
    input  in_ready_o, out_valid_o, ntt_data1_o, ntt_data2_o, inflight_o
  );
endinterface

// File: rtl/ntt_bu_pipe.sv
// Four-stage modular butterfly (Cooley-Tukey / Gentleman-Sande) with a single
// global stall: every stage advances together whenever the output is free.
module ntt_bu_pipe #(
  parameter int unsigned     DATA_WIDTH = 32,
  parameter longint unsigned Val_Q      = 8380417,
  parameter int unsigned     STAGES     = 4
) (
  input logic          clk_i,
  input logic          reset_ni,
  ntt_bu_pipe_if.slave bus
);

  localparam int unsigned W = DATA_WIDTH;
  localparam logic [W-1:0]   Q  = Val_Q[W-1:0];
  localparam logic [W:0]     QE = {1'b0, Q};
  localparam logic [2*W-1:0] QP = {{W{1'b0}}, Q};

  if (STAGES != 4) begin : g_bad_stages
    $error("ntt_bu_pipe supports only STAGES == 4");
  end

  function automatic logic [W-1:0] mod_red(input logic [W-1:0] x);
    return x % Q;
  endfunction

  function automatic logic [W-1:0] mod_add(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= QE) s = s - QE;
    return s[W-1:0];
  endfunction

  // Borrow is detected by magnitude compare; adding Q back wraps to the right residue.
  function automatic logic [W-1:0] mod_sub(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] d;
    d = {1'b0, x} - {1'b0, y};
    if (x < y) d = d + QE;
    return d[W-1:0];
  endfunction

  function automatic logic [W-1:0] mod_mul(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W-1:0] p;
    p = ({{W{1'b0}}, x} * {{W{1'b0}}, y}) % QP;
    return p[W-1:0];
  endfunction

  logic         v1, v2, v3, v4;
  logic         m1, m2, m3;
  logic [W-1:0] a1, b1, w1;
  logic [W-1:0] a2, b2, w2;
  logic [W-1:0] a3, p3;
  logic [W-1:0] d1, d2;
  logic [2:0]   inflight;
  logic         adv, xfer_in, xfer_out;

  assign adv      = !v4 || bus.out_ready_i;
  assign xfer_in  = bus.in_valid_i && adv;
  assign xfer_out = v4 && bus.out_ready_i;

  assign bus.in_ready_o  = adv;
  assign bus.out_valid_o = v4;
  assign bus.ntt_data1_o = d1;
  assign bus.ntt_data2_o = d2;
  assign bus.inflight_o  = inflight;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0; v4 <= 1'b0;
      m1 <= 1'b0; m2 <= 1'b0; m3 <= 1'b0;
      a1 <= '0; b1 <= '0; w1 <= '0;
      a2 <= '0; b2 <= '0; w2 <= '0;
      a3 <= '0; p3 <= '0;
      d1 <= '0; d2 <= '0;
      inflight <= '0;
    end else begin
      if (xfer_in && !xfer_out)      inflight <= inflight + 3'd1;
      else if (!xfer_in && xfer_out) inflight <= inflight - 3'd1;

      if (adv) begin
        v1 <= bus.in_valid_i;
        m1 <= bus.mode_i;
        a1 <= mod_red(bus.data1_i);
        b1 <= mod_red(bus.data2_i);
        w1 <= mod_red(bus.w_i);

        v2 <= v1;
        m2 <= m1;
        w2 <= w1;
        if (m1) begin
          a2 <= mod_add(a1, b1);
          b2 <= mod_sub(a1, b1);
        end else begin
          a2 <= a1;
          b2 <= b1;
        end

        // Stage 3 multiplies whatever stage 2 left in b2: b (forward) or a-b (inverse).
        v3 <= v2;
        m3 <= m2;
        a3 <= a2;
        p3 <= mod_mul(b2, w2);

        v4 <= v3;
        if (!v3) begin
          d1 <= '0;
          d2 <= '0;
        end else if (m3) begin
          d1 <= a3;
          d2 <= p3;
        end else begin
          d1 <= mod_add(a3, p3);
          d2 <= mod_sub(a3, p3);
        end
      end
    end
  end

endmodule
